// File: rtl/led_band_pkg.sv
// ============================================================================
//  Module   : led_band_pkg
//  Purpose  : Shared types, default widths and lane helper for the LED-band
//             ping-pong frame buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_band_pkg;

   localparam int C_W_ADDR_WIDTH = 11;
   localparam int C_W_DATA_WIDTH = 128;
   localparam int C_R_DATA_WIDTH = 8;

   typedef enum logic [0:0] {
      BACK_FILL = 1'b0,
      BACK_FULL = 1'b1
   } bank_state_t;

   // Number of address bits that select a narrow lane inside one wide word.
   function automatic int lane_bits(input int w_width, input int r_width);
      return $clog2(w_width / r_width);
   endfunction

endpackage

`default_nettype wire

// File: rtl/led_band_ram_bank.sv
// ============================================================================
//  Module   : led_band_ram_bank
//  Purpose  : One bank of wide-write / narrow-read simple dual-port RAM with a
//             registered, enabled read port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_band_ram_bank
   import led_band_pkg::*;
#(
   parameter int W_ADDR_WIDTH = C_W_ADDR_WIDTH,
   parameter int W_DATA_WIDTH = C_W_DATA_WIDTH,
   parameter int R_DATA_WIDTH = C_R_DATA_WIDTH,
   parameter int LANE_BITS    = lane_bits(W_DATA_WIDTH, R_DATA_WIDTH),
   parameter int LANE_W       = (LANE_BITS > 0) ? LANE_BITS : 1
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [W_ADDR_WIDTH-1:0] waddr,
   input  logic [W_DATA_WIDTH-1:0] wdata,
   input  logic                    re,
   input  logic [W_ADDR_WIDTH-1:0] raddr,
   input  logic [LANE_W-1:0]       rlane,
   output logic [R_DATA_WIDTH-1:0] rdata
);

   localparam int RATIO = W_DATA_WIDTH / R_DATA_WIDTH;

   logic [W_DATA_WIDTH-1:0] r_mem [2**W_ADDR_WIDTH];
   logic [W_DATA_WIDTH-1:0] r_word;

   // Plain unreset array with a registered full-word read keeps this a block RAM;
   // the lane mux sits after the RAM output register.
   always_ff @(posedge clk) begin
      if (we)
         r_mem[waddr] <= wdata;
      if (re)
         r_word <= r_mem[raddr];
   end

   generate
      if (LANE_BITS == 0) begin : g_single
         assign rdata = r_word;
      end else begin : g_multi
         logic [LANE_BITS-1:0]    r_lane;
         logic [R_DATA_WIDTH-1:0] w_lanes [RATIO];

         always_ff @(posedge clk) begin
            if (re)
               r_lane <= rlane;
         end

         for (genvar i = 0; i < RATIO; i++) begin : g_lane
            assign w_lanes[i] = r_word[i*R_DATA_WIDTH +: R_DATA_WIDTH];
         end

         assign rdata = w_lanes[r_lane];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/led_band_frame_buffer.sv
// ============================================================================
//  Module   : led_band_frame_buffer
//  Purpose  : Tear-free ping-pong frame buffer: wide writes to the back bank,
//             narrow reads from the front bank, swap on commit + reader sync.
//             Optional underrun counter: define LED_BAND_FB_UNDERRUN_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_band_frame_buffer
   import led_band_pkg::*;
#(
   parameter int W_ADDR_WIDTH = C_W_ADDR_WIDTH,
   parameter int W_DATA_WIDTH = C_W_DATA_WIDTH,
   parameter int R_DATA_WIDTH = C_R_DATA_WIDTH,
   localparam int LANE_BITS    = lane_bits(W_DATA_WIDTH, R_DATA_WIDTH),
   localparam int R_ADDR_WIDTH = W_ADDR_WIDTH + LANE_BITS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    write,
   input  logic [W_ADDR_WIDTH-1:0] w_addr,
   input  logic [W_DATA_WIDTH-1:0] w_data,
   input  logic                    w_commit,
   output logic                    w_ready,
   input  logic                    read,
   input  logic [R_ADDR_WIDTH-1:0] r_addr,
   output logic [R_DATA_WIDTH-1:0] r_data,
   output logic                    r_valid,
   input  logic                    r_sync,
   output logic                    front_bank,
   output logic                    swap
`ifdef LED_BAND_FB_UNDERRUN_CNT_EN
   ,
   output logic [15:0]             underrun_cnt
`endif
);

   localparam int RATIO  = W_DATA_WIDTH / R_DATA_WIDTH;
   localparam int LANE_W = (LANE_BITS > 0) ? LANE_BITS : 1;

   generate
      if ((R_DATA_WIDTH < 1) || (W_DATA_WIDTH % R_DATA_WIDTH != 0) ||
          (RATIO < 1) || ((RATIO & (RATIO - 1)) != 0)) begin : g_bad_ratio
         $error("W_DATA_WIDTH/R_DATA_WIDTH must be a power of two >= 1");
      end
   endgenerate

   bank_state_t             r_state;
   logic                    r_rd_bank;
   logic                    r_has_data;
   logic                    w_wr_en;
   logic [W_ADDR_WIDTH-1:0] w_word;
   logic [LANE_W-1:0]       w_lane;
   logic [R_DATA_WIDTH-1:0] w_bank_rdata [2];

   assign w_wr_en = write && (r_state == BACK_FILL);
   assign w_word  = r_addr[R_ADDR_WIDTH-1 -: W_ADDR_WIDTH];

   generate
      if (LANE_BITS == 0) begin : g_no_lane
         assign w_lane = '0;
      end else begin : g_lane_sel
         assign w_lane = r_addr[LANE_BITS-1:0];
      end

      for (genvar b = 0; b < 2; b++) begin : g_bank
         led_band_ram_bank #(
            .W_ADDR_WIDTH (W_ADDR_WIDTH),
            .W_DATA_WIDTH (W_DATA_WIDTH),
            .R_DATA_WIDTH (R_DATA_WIDTH),
            .LANE_BITS    (LANE_BITS),
            .LANE_W       (LANE_W)
         ) u_bank (
            .clk   (clk),
            .we    (w_wr_en && (front_bank != 1'(b))),
            .waddr (w_addr),
            .wdata (w_data),
            .re    (read && (front_bank == 1'(b))),
            .raddr (w_word),
            .rlane (w_lane),
            .rdata (w_bank_rdata[b])
         );
      end
   endgenerate

   // RAM output registers are unreset; gate them until the first read lands.
   assign r_data = r_has_data ? w_bank_rdata[r_rd_bank] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_has_data <= 1'b0;
      end else begin
         r_valid <= read;
         if (read) begin
            r_rd_bank  <= front_bank;
            r_has_data <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= BACK_FILL;
         front_bank <= 1'b0;
         w_ready    <= 1'b1;
         swap       <= 1'b0;
`ifdef LED_BAND_FB_UNDERRUN_CNT_EN
         underrun_cnt <= 16'h0000;
`endif
      end else begin
         swap <= 1'b0;
         case (r_state)
            BACK_FILL: begin
               // A sync here (even alongside commit) just repeats the front frame.
               if (w_commit) begin
                  r_state <= BACK_FULL;
                  w_ready <= 1'b0;
               end
`ifdef LED_BAND_FB_UNDERRUN_CNT_EN
               if (r_sync && (underrun_cnt != 16'hFFFF))
                  underrun_cnt <= underrun_cnt + 16'd1;
`endif
            end
            BACK_FULL: begin
               if (r_sync) begin
                  r_state    <= BACK_FILL;
                  front_bank <= ~front_bank;
                  swap       <= 1'b1;
                  w_ready    <= 1'b1;
               end
            end
            default: begin
               r_state <= BACK_FILL;
               w_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_led_band_frame_buffer.sv
// ============================================================================
//  Module   : tb_led_band_frame_buffer
//  Purpose  : Directed scoreboard bench for led_band_frame_buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_band_frame_buffer;

   localparam int W_ADDR_WIDTH = 11;
   localparam int W_DATA_WIDTH = 128;
   localparam int R_DATA_WIDTH = 8;
   localparam int R_ADDR_WIDTH = 15;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    write;
   logic [W_ADDR_WIDTH-1:0] w_addr;
   logic [W_DATA_WIDTH-1:0] w_data;
   logic                    w_commit;
   logic                    w_ready;
   logic                    read;
   logic [R_ADDR_WIDTH-1:0] r_addr;
   logic [R_DATA_WIDTH-1:0] r_data;
   logic                    r_valid;
   logic                    r_sync;
   logic                    front_bank;
   logic                    swap;
`ifdef LED_BAND_FB_UNDERRUN_CNT_EN
   logic [15:0]             underrun_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [R_DATA_WIDTH-1:0] exp_q [$];

   led_band_frame_buffer dut (
      .clk        (clk),
      .rst        (rst),
      .write      (write),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .w_commit   (w_commit),
      .w_ready    (w_ready),
      .read       (read),
      .r_addr     (r_addr),
      .r_data     (r_data),
      .r_valid    (r_valid),
      .r_sync     (r_sync),
      .front_bank (front_bank),
      .swap       (swap)
`ifdef LED_BAND_FB_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_read(input int addr, input logic [7:0] exp);
      read   = 1'b1;
      r_addr = R_ADDR_WIDTH'(addr);
      exp_q.push_back(exp);
   endtask

   function automatic logic [127:0] ramp(input logic [7:0] base);
      logic [127:0] d;
      for (int i = 0; i < 16; i++)
         d[i*8 +: 8] = base + 8'(i);
      return d;
   endfunction

   // Read-data monitor: every r_valid beat is matched against the next expected byte.
   always @(negedge clk) begin
      if (!rst && r_valid) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rd_unexpected: got 0x%0h, expected no read data", r_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (r_data !== e) begin
               n_err++;
               $display("FAIL rd_data: got 0x%0h, expected 0x%0h", r_data, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; write = 1'b0; w_addr = '0; w_data = '0; w_commit = 1'b0;
      read = 1'b0; r_addr = '0; r_sync = 1'b0;
      repeat (3) tick();
      check("rst_w_ready", 32'(w_ready), 32'd1);
      check("rst_front",   32'(front_bank), 32'd0);
      check("rst_r_valid", 32'(r_valid), 32'd0);
      check("rst_swap",    32'(swap), 32'd0);
      check("rst_r_data",  32'(r_data), 32'd0);
      rst = 1'b0;
      tick();

      // Fill back bank (bank 1) word 0 with lanes 0x00..0x0F, then commit.
      write = 1'b1; w_addr = '0; w_data = ramp(8'h00);
      tick();
      write = 1'b0; w_commit = 1'b1;
      tick();
      w_commit = 1'b0;
      check("commit_w_ready", 32'(w_ready), 32'd0);

      // Writes while full must be dropped.
      write = 1'b1; w_addr = '0; w_data = '1;
      tick();
      write = 1'b0;
      check("full_w_ready", 32'(w_ready), 32'd0);
      check("full_no_swap", 32'(swap), 32'd0);

      r_sync = 1'b1;
      tick();
      r_sync = 1'b0;
      check("swap1_pulse", 32'(swap), 32'd1);
      check("swap1_front", 32'(front_bank), 32'd1);
      check("swap1_w_ready", 32'(w_ready), 32'd1);
      tick();
      check("swap1_pulse_end", 32'(swap), 32'd0);

      for (int i = 0; i < 16; i++) begin
         issue_read(i, 8'(i));
         tick();
      end
      read = 1'b0;
      tick();
      check("idle_r_valid", 32'(r_valid), 32'd0);
      check("idle_r_hold",  32'(r_data), 32'h0F);

      // Back bank is now bank 0: fill it, then commit and sync together.
      write = 1'b1; w_addr = '0; w_data = ramp(8'h20);
      tick();
      write = 1'b0; w_commit = 1'b1; r_sync = 1'b1;
      tick();
      w_commit = 1'b0; r_sync = 1'b0;
      check("cs_no_swap",  32'(swap), 32'd0);
      check("cs_front",    32'(front_bank), 32'd1);
      check("cs_w_ready",  32'(w_ready), 32'd0);
      tick();

      // Read in the same cycle as the swap: served by the old front bank.
      r_sync = 1'b1;
      issue_read(3, 8'h03);
      tick();
      r_sync = 1'b0;
      check("swap2_pulse", 32'(swap), 32'd1);
      check("swap2_front", 32'(front_bank), 32'd0);
      issue_read(3, 8'h23);
      tick();
      issue_read(15, 8'h2F);
      tick();
      read = 1'b0;
      tick();

      // Get front back to bank 1, then abort a half-written frame with reset.
      w_commit = 1'b1;
      tick();
      w_commit = 1'b0; r_sync = 1'b1;
      tick();
      r_sync = 1'b0;
      check("swap3_front", 32'(front_bank), 32'd1);
      for (int i = 0; i < 5; i++) begin
         write = 1'b1; w_addr = W_ADDR_WIDTH'(i + 1); w_data = ramp(8'(8'h40 + i));
         if (i == 4)
            issue_read(5, 8'h05);
         tick();
      end
      write = 1'b0; read = 1'b0;
      check("pre_rst_r_valid", 32'(r_valid), 32'd1);
      #6;
      rst = 1'b1;
      #1;
      check("mid_rst_w_ready", 32'(w_ready), 32'd1);
      check("mid_rst_front",   32'(front_bank), 32'd0);
      check("mid_rst_r_valid", 32'(r_valid), 32'd0);
      check("mid_rst_r_data",  32'(r_data), 32'd0);
      check("mid_rst_swap",    32'(swap), 32'd0);
      tick();
      rst = 1'b0;
      tick();

`ifdef LED_BAND_FB_UNDERRUN_CNT_EN
      check("ucnt_rst", 32'(underrun_cnt), 32'd0);
      r_sync = 1'b1;
      repeat (3) tick();
      r_sync = 1'b0;
      check("ucnt_3", 32'(underrun_cnt), 32'd3);
      r_sync = 1'b1;
      repeat (65532) tick();
      r_sync = 1'b0;
      check("ucnt_max", 32'(underrun_cnt), 32'hFFFF);
      r_sync = 1'b1;
      tick();
      r_sync = 1'b0;
      check("ucnt_sat", 32'(underrun_cnt), 32'hFFFF);
`endif

      tick();
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
